// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Purpose  : Shared state encodings and framing constants for the UART blocks.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4,
        MARK  = 3'd5
    } uart_state_t;

    localparam int          FRAME_BITS              = 10;
    localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd868;
    localparam logic [3:0]  LAST_DATA_BIT           = 4'd7;
    // MARK reuses the bit counter to time one idle frame after a break.
    localparam logic [3:0]  LAST_MARK_BIT           = 4'(FRAME_BITS - 1);

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Reloadable down-counter; o_zero flags the last clock of a period.
// Revision : 1.0
// ============================================================================
module uart_baud_tick #(
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Parks at zero when not reloaded so the owner can treat zero as "period done".
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/txuart_8n1.sv
`default_nettype none
// ============================================================================
// Module   : txuart_8n1
// Purpose  : 8N1 serial transmitter with busy handshake and line-break mode.
// Revision : 1.0
// ============================================================================
module txuart_8n1
    import uart_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    input  logic       i_break,
    output logic       o_uart_tx,
    output logic       o_busy
);

    localparam logic [23:0] c_RELOAD = CLOCKS_PER_BAUD - 24'd1;

    uart_state_t r_state;
    uart_state_t w_state_nxt;
    logic [3:0]  r_bit;
    logic [3:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        w_load;
    logic        w_tick;
    logic        w_accept;

    uart_baud_tick #(
        .WIDTH (24)
    ) u_baud (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (w_load),
        .i_load_val (c_RELOAD),
        .o_zero     (w_tick)
    );

    // Ready to take a write/break: idle, or the final clock of a stop bit or mark frame.
    assign w_accept = (r_state == IDLE)
                   || ((r_state == STOP) && w_tick)
                   || ((r_state == MARK) && w_tick && (r_bit == LAST_MARK_BIT));

    assign o_busy = ~w_accept;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_bit   <= 4'd0;
            r_shift <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;

        if (w_accept) begin
            w_bit_nxt = 4'd0;
            if (i_break) begin
                w_state_nxt = BREAK;
            end else if (i_wr) begin
                w_state_nxt = START;
                w_shift_nxt = i_data;
                w_load      = 1'b1;
            end else begin
                w_state_nxt = IDLE;
            end
        end else begin
            case (r_state)
                START: begin
                    if (w_tick) begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = 4'd0;
                        w_load      = 1'b1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_load      = 1'b1;
                        if (r_bit == LAST_DATA_BIT) begin
                            w_state_nxt = STOP;
                            w_bit_nxt   = 4'd0;
                        end else begin
                            w_bit_nxt   = r_bit + 4'd1;
                        end
                    end
                end
                BREAK: begin
                    if (!i_break) begin
                        w_state_nxt = MARK;
                        w_bit_nxt   = 4'd0;
                        w_load      = 1'b1;
                    end
                end
                MARK: begin
                    if (w_tick) begin
                        w_bit_nxt = r_bit + 4'd1;
                        w_load    = 1'b1;
                    end
                end
                STOP: begin
                    w_state_nxt = STOP;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_bit_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Line is decoded from state so reset drives it high without waiting for a clock.
    always_comb begin
        o_uart_tx = 1'b1;
        case (r_state)
            START:   o_uart_tx = 1'b0;
            DATA:    o_uart_tx = r_shift[0];
            BREAK:   o_uart_tx = 1'b0;
            default: o_uart_tx = 1'b1;
        endcase
    end

endmodule
`default_nettype wire
